// File: rtl/afisare_pkg.sv
// Shared definitions for the two-digit lap-count display driver:
// scan state encoding and active-high 7-segment glyphs {g,f,e,d,c,b,a}.
package afisare_pkg;

  typedef enum logic [1:0] {
    S_UNI  = 2'd0,
    S_GAP1 = 2'd1,
    S_ZECI = 2'd2,
    S_GAP2 = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Entry d holds the glyph for digit d
  localparam logic [9:0][6:0] GLYPH = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/afisare_ture_dec_7seg.sv
// BCD to 7-segment decoder, active-high segments.
// Non-decimal codes show a dash so a bad input is never mistaken for blank.
module dec_7seg
  import afisare_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) o_seg = GLYPH[i_bcd];
  end

endmodule

// File: rtl/afisare_ture.sv
// Two-digit multiplexed common-anode display driver for the lap count.
// Synchronised digit bus, once-per-frame snapshot, dead time between digits.
module afisare_ture
  import afisare_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic       tact,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cifra_unitati,
  input  logic [3:0] cifra_zeci,
  output logic [6:0] seg,
  output logic [1:0] anod,
  output logic       frame_done
);

  localparam int MAXC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int DW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [DW-1:0] SCAN_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

  localparam logic [6:0] SEG_IDLE =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : SEG_OFF;
  localparam logic [1:0] AN_IDLE =
    (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_stable;
  logic [7:0]    r_snap;
  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [6:0]    r_seg;
  logic [1:0]    r_anod;
  logic          r_fd;

  logic [6:0] w_seg_u;
  logic [6:0] w_seg_z;
  logic       w_scan;
  logic       w_last;
  logic       w_blank;

  // Accept only values seen identically on two consecutive edges
  always_ff @(posedge tact or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= {cifra_zeci, cifra_unitati};
      r_sync2 <= r_sync1;
      if (r_sync1 == r_sync2) r_stable <= r_sync2;
    end
  end

  dec_7seg u_dec_u (
    .i_bcd (r_snap[3:0]),
    .o_seg (w_seg_u)
  );

  dec_7seg u_dec_z (
    .i_bcd (r_snap[7:4]),
    .o_seg (w_seg_z)
  );

  assign w_scan  = (r_state == S_UNI) || (r_state == S_ZECI);
  assign w_last  = r_div == (w_scan ? SCAN_LAST : DEAD_LAST);
  assign w_blank = (BLANK_LEADING != 0) && (r_snap[7:4] == 4'd0);

  always_ff @(posedge tact or negedge reset) begin
    if (!reset) begin
      r_state <= S_GAP2;
      r_div   <= '0;
      r_snap  <= '0;
      r_seg   <= SEG_IDLE;
      r_anod  <= AN_IDLE;
      r_fd    <= 1'b0;
    end else if (!en) begin
      r_state <= S_GAP2;
      r_div   <= '0;
      r_seg   <= SEG_IDLE;
      r_anod  <= AN_IDLE;
      r_fd    <= 1'b0;
    end else begin
      r_seg  <= SEG_IDLE;
      r_anod <= AN_IDLE;
      r_fd   <= 1'b0;
      r_div  <= w_last ? '0 : r_div + 1'b1;
      unique case (r_state)
        S_UNI: begin
          r_seg  <= w_seg_u ^ SEG_IDLE;
          r_anod <= AN_IDLE ^ 2'b01;
          if (w_last) r_state <= S_GAP1;
        end
        S_GAP1: begin
          if (w_last) r_state <= S_ZECI;
        end
        S_ZECI: begin
          if (!w_blank) begin
            r_seg  <= w_seg_z ^ SEG_IDLE;
            r_anod <= AN_IDLE ^ 2'b10;
          end
          if (w_last) r_state <= S_GAP2;
        end
        S_GAP2: begin
          // New digits only enter here, so a frame never tears
          if (w_last) begin
            r_state <= S_UNI;
            r_snap  <= r_stable;
            r_fd    <= 1'b1;
          end
        end
        default: r_state <= S_GAP2;
      endcase
    end
  end

  assign seg        = r_seg;
  assign anod       = r_anod;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_afisare_ture.sv
// Bench for afisare_ture: frame-level model plus fixed glyph expectations.
// Two instances run side by side, leading-zero blanking on and off.
module tb_afisare_ture;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FR = 2 * (SD + DC);

  logic       tact  = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b1;
  logic [3:0] cu    = 4'd0;
  logic [3:0] cz    = 4'd0;

  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic       fd0, fd1;

  always #5 tact = ~tact;

  afisare_ture #(
    .SCAN_DIV(SD), .DEAD_CYC(DC), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut_b (
    .tact(tact), .reset(reset), .en(en),
    .cifra_unitati(cu), .cifra_zeci(cz),
    .seg(seg0), .anod(an0), .frame_done(fd0)
  );

  afisare_ture #(
    .SCAN_DIV(SD), .DEAD_CYC(DC), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLANK_LEADING(0)
  ) dut_n (
    .tact(tact), .reset(reset), .en(en),
    .cifra_unitati(cu), .cifra_zeci(cz),
    .seg(seg1), .anod(an1), .frame_done(fd1)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_fd = -1;

  int         n;
  logic [7:0] samp [3];
  logic [7:0] m_stable;
  logic [7:0] m_snap;
  logic [6:0] e_seg0, e_seg1;
  logic [1:0] e_an0, e_an1;
  logic       e_fd;

  logic seen4, seen7, seen_dash, seen6;

  function automatic logic [6:0] glyph_low(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int phase();
    return (n + FR - DC) % FR;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 3; i++) samp[i] = 8'h00;
    m_stable = 8'h00;
    m_snap   = 8'h00;
    e_seg0 = 7'h7F; e_seg1 = 7'h7F;
    e_an0  = 2'b11; e_an1  = 2'b11;
    e_fd   = 1'b0;
    last_fd = -1;
  endtask

  // Expected pins after one rising edge, from the frame timeline
  task automatic model_edge();
    logic [7:0] old_stable;
    int p;
    old_stable = m_stable;
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = {cz, cu};
    if (samp[1] == samp[2]) m_stable = samp[2];
    e_seg0 = 7'h7F; e_seg1 = 7'h7F;
    e_an0  = 2'b11; e_an1  = 2'b11;
    e_fd   = 1'b0;
    if (!en) begin
      n = 0;
      last_fd = -1;
    end else begin
      p = phase();
      if (p < SD) begin
        e_seg0 = glyph_low(m_snap[3:0]);
        e_seg1 = e_seg0;
        e_an0  = 2'b10;
        e_an1  = 2'b10;
      end else if (p >= SD + DC && p < 2 * SD + DC) begin
        e_seg1 = glyph_low(m_snap[7:4]);
        e_an1  = 2'b01;
        if (m_snap[7:4] != 4'd0) begin
          e_seg0 = e_seg1;
          e_an0  = 2'b01;
        end
      end
      if (p == FR - 1) begin
        e_fd   = 1'b1;
        m_snap = old_stable;
      end
      n++;
    end
  endtask

  task automatic step();
    @(posedge tact);
    model_edge();
    @(negedge tact);
    cyc++;
    check("seg_blank",   seg0, e_seg0);
    check("anod_blank",  an0,  e_an0);
    check("fd_blank",    fd0,  e_fd);
    check("seg_noblank", seg1, e_seg1);
    check("anod_noblank", an1, e_an1);
    check("fd_noblank",  fd1,  e_fd);
    if (an0 == 2'b10 && seg0 == 7'b0011001) seen4 = 1'b1;
    if (an0 == 2'b01 && seg0 == 7'b1111000) seen7 = 1'b1;
    if (an0 == 2'b01 && seg0 == 7'b0111111) seen_dash = 1'b1;
    if (an0 == 2'b10 && seg0 == 7'b0000010) seen6 = 1'b1;
    if (fd0) begin
      if (last_fd >= 0) check("period", cyc - last_fd, FR);
      last_fd = cyc;
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic goto_phase(input int ph);
    for (int i = 0; i < 2 * FR && phase() != ph; i++) step();
  endtask

  initial begin
    seen4 = 0; seen7 = 0; seen_dash = 0; seen6 = 0;
    model_reset();
    cu = 4'd3; cz = 4'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge tact);
    check("rst_seg",  seg0, 7'h7F);
    check("rst_anod", an0,  2'b11);
    check("rst_fd",   fd0,  1'b0);
    reset = 1'b1;

    step();
    check("first_dark_fd", fd0, 1'b0);
    step();
    check("first_fd", fd0, 1'b1);
    steps(21);
    check("units3_seg",  seg0, 7'b0110000);
    check("units3_anod", an0,  2'b10);
    steps(10);
    check("tens0_blank_anod", an0,  2'b11);
    check("tens0_blank_seg",  seg0, 7'h7F);
    check("tens0_lit_anod",   an1,  2'b01);
    check("tens0_lit_seg",    seg1, 7'b1000000);

    cu = 4'd4; cz = 4'd7;
    steps(45);
    check("seen_units4", seen4, 1'b1);
    check("seen_tens7",  seen7, 1'b1);

    goto_phase(3);
    cu = 4'd5;
    steps(2);
    check("hold4_seg", seg0, 7'b0011001);
    steps(45);

    cz = 4'hA;
    steps(45);
    check("seen_dash", seen_dash, 1'b1);

    goto_phase(2);
    seen6 = 0;
    cu = 4'd6;
    step();
    cu = 4'd5;
    steps(45);
    check("glitch_ignored", seen6, 1'b0);

    goto_phase(12);
    en = 1'b0;
    step();
    check("en0_anod", an0,  2'b11);
    check("en0_seg",  seg0, 7'h7F);
    steps(4);
    en = 1'b1;
    step();
    check("en1_dark_fd", fd0, 1'b0);
    step();
    check("en1_fd", fd0, 1'b1);
    step();
    check("en1_uni_anod", an0, 2'b10);
    steps(25);

    goto_phase(3);
    #2 reset = 1'b0;
    #1;
    check("async_rst_anod", an0,  2'b11);
    check("async_rst_seg",  seg0, 7'h7F);
    check("async_rst_fd",   fd0,  1'b0);
    model_reset();
    @(negedge tact);
    reset = 1'b1;
    steps(45);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) cu = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) cz = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) en = 1'b0;
      else if ($urandom_range(3) == 0) en = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
